lin_curves_bank_ctl: RTL
========================

Name: lin_curves_bank_ctl

Overview:
- Double-buffer bank controller for the piecewise-linear curve tables: 256-entry offset ROM (16 bit) and 256-entry slope ROM (11 bit), addressed {bank, qphase, mag[15:11]}.
- Host writes go only to the shadow (inactive) bank; the live `bank` bit flips only on a safe datapath boundary (frame_stb).
- After a flip, the old bank stays write-locked until in-flight lookups have drained.
- Sits between the host register decoder and the offset/slope table RAMs; drives the `bank` input of the curve pipeline.

Parameters:
- drain_len, 4, cycles the old bank stays write-locked after a flip (≥ curve pipeline latency + extra_delay); legal range 1..255.
- arm_timeout, 0, cycles in ARMED before a forced flip without frame_stb; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- wr_stb  in  1  host table-write strobe (one-cycle pulse)
- wr_sel  in  1  0 = offset table, 1 = slope table
- wr_addr  in  7  {qphase[1:0], segment[4:0]} within the bank
- wr_data  in  16  write data; slope uses [10:0]
- swap_req  in  1  host request to publish the shadow bank (pulse)
- frame_stb  in  1  safe-boundary strobe from the datapath
- clr_status  in  1  clears reject_cnt and swap_err
- bank  out  1  live bank to the curve datapath
- offs_we  out  1  offset RAM write enable
- slope_we  out  1  slope RAM write enable
- ram_waddr  out  8  {shadow bank, wr_addr}
- ram_wdata  out  16  registered wr_data
- wr_ack  out  1  write accepted (pulse, aligned with the *_we outputs)
- state_o  out  2  0 = IDLE, 1 = ARMED, 2 = DRAIN
- dirty  out  1  shadow bank written since last flip
- reject_cnt  out  8  rejected writes, saturating at 255
- swap_err  out  1  sticky: swap_req arrived outside IDLE, or with dirty = 0

Behaviour:
- Reset (rst_n low at a clk edge):
  - bank = 0, state IDLE, dirty = 0, reject_cnt = 0, swap_err = 0.
  - All *_we and wr_ack = 0; ram_waddr = 0, ram_wdata = 0.
  - Reset mid-ARMED or mid-DRAIN abandons the swap, returns bank to 0, and drops any write in the pipeline register.
- Write path, latency 1:
  - A wr_stb accepted at edge N drives offs_we (wr_sel = 0) or slope_we (wr_sel = 1) high for exactly one cycle after edge N+1.
  - ram_waddr = {~bank as of edge N, wr_addr}, ram_wdata = wr_data; wr_ack is high in the same cycle as the enable.
  - Writes are accepted only in IDLE. Acceptance sets dirty.
  - A wr_stb in ARMED or DRAIN is rejected: no enables, no ack, reject_cnt += 1 (holds at 255).
- IDLE:
  - swap_req with dirty = 1 → ARMED next cycle.
  - swap_req with dirty = 0 → stay IDLE, set swap_err.
  - wr_stb and swap_req in the same cycle: the write is accepted and counts toward dirty, so the swap is armed.
- ARMED:
  - frame_stb → bank toggles at the next edge, dirty clears, drain counter loads drain_len, state DRAIN.
  - If arm_timeout > 0 and arm_timeout cycles pass in ARMED without frame_stb → same forced flip.
  - A frame_stb in the same cycle that swap_req arrives in IDLE does not flip; the flip waits for the next frame_stb while ARMED.
  - swap_req while ARMED: ignored, sets swap_err.
- DRAIN:
  - The counter decrements each cycle; when it reaches 0 → IDLE.
  - First writable cycle is drain_len + 1 cycles after the bank edge.
  - frame_stb is ignored; swap_req sets swap_err.
- Status:
  - clr_status zeroes reject_cnt and swap_err at the next edge.
  - If clr_status and a new error arrive in the same cycle, the error wins: reject_cnt = 1 or swap_err = 1.
- Invariant: ram_waddr[7] never equals bank while any *_we is high.

Test Plan:
- Reset, write offset addr 0x25 data 0x1234 → offs_we pulses 1 cycle later, ram_waddr = 0xA5, ram_wdata = 0x1234, wr_ack = 1, dirty = 1, bank = 0.
- swap_req, frame_stb 10 cycles later → bank = 1 at the following edge, state DRAIN for 4 cycles then IDLE; slope write addr 0x03 then → ram_waddr = 0x03, slope_we = 1.
- Three wr_stb during ARMED plus one during DRAIN → no enables, reject_cnt = 4; clr_status → 0; clr_status with a coincident reject → 1.
- swap_req with dirty = 0 → state stays IDLE, swap_err = 1; swap_req during DRAIN → swap_err = 1, bank unchanged.
- arm_timeout = 16, swap_req, no frame_stb → bank flips on exactly the 16th ARMED cycle; with arm_timeout = 0 and no frame_stb for 1000 cycles → bank never flips.
- rst_n low during DRAIN (bank = 1) → bank = 0, IDLE, dirty = 0 next cycle; a write presented in the reset cycle produces no enable.

Source files
------------

// File: rtl/lin_curves_bank_ctl.sv
// Double-buffer bank controller for the piecewise-linear curve tables.
// Host writes land in the shadow bank; the live bank flips on frame_stb.
module lin_curves_bank_ctl #(
    parameter int unsigned DRAIN_LEN   = 4,
    parameter int unsigned ARM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_stb,
    input  logic        wr_sel,
    input  logic [6:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        swap_req,
    input  logic        frame_stb,
    input  logic        clr_status,
    output logic        bank,
    output logic        offs_we,
    output logic        slope_we,
    output logic [7:0]  ram_waddr,
    output logic [15:0] ram_wdata,
    output logic        wr_ack,
    output logic [1:0]  state_o,
    output logic        dirty,
    output logic [7:0]  reject_cnt,
    output logic        swap_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam int unsigned TW =
        (ARM_TIMEOUT < 2) ? 1 : $clog2(ARM_TIMEOUT + 1);
    localparam logic [TW-1:0] ARM_LAST =
        TW'((ARM_TIMEOUT == 0) ? 0 : ARM_TIMEOUT - 1);
    localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_LEN);

    state_e        state_q, state_d;
    logic          bank_q, bank_d;
    logic          dirty_q, dirty_d;
    logic [7:0]    drain_q, drain_d;
    logic [TW-1:0] arm_q, arm_d;
    logic [7:0]    rej_q, rej_d;
    logic          err_q, err_d;
    logic          owe_q, owe_d;
    logic          swe_q, swe_d;
    logic          ack_q, ack_d;
    logic [7:0]    waddr_q, waddr_d;
    logic [15:0]   wdata_q, wdata_d;

    logic accept;
    logic reject;
    logic serr;
    logic timeout;

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        dirty_d = dirty_q;
        drain_d = drain_q;
        arm_d   = arm_q;
        accept  = 1'b0;
        reject  = 1'b0;
        serr    = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                accept = wr_stb;
                if (swap_req) begin
                    // a write in the same cycle already makes the shadow dirty
                    if (dirty_q || wr_stb) begin
                        state_d = S_ARMED;
                        arm_d   = '0;
                    end else begin
                        serr = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                reject  = wr_stb;
                serr    = swap_req;
                timeout = (ARM_TIMEOUT != 0) && (arm_q == ARM_LAST);
                if (frame_stb || timeout) begin
                    state_d = S_DRAIN;
                    bank_d  = ~bank_q;
                    dirty_d = 1'b0;
                    drain_d = DRAIN_INIT;
                end else if (ARM_TIMEOUT != 0) begin
                    arm_d = arm_q + 1'b1;
                end
            end
            S_DRAIN: begin
                reject = wr_stb;
                serr   = swap_req;
                if (drain_q <= 8'd1) begin
                    state_d = S_IDLE;
                    drain_d = 8'd0;
                end else begin
                    drain_d = drain_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            dirty_d = 1'b1;
        end
    end

    always_comb begin
        rej_d = clr_status ? 8'd0 : rej_q;
        if (reject && (rej_d != 8'hFF)) begin
            rej_d = rej_d + 8'd1;
        end
        err_d = (clr_status ? 1'b0 : err_q) | serr;
    end

    always_comb begin
        owe_d   = accept & ~wr_sel;
        swe_d   = accept & wr_sel;
        ack_d   = accept;
        waddr_d = accept ? {~bank_q, wr_addr} : waddr_q;
        wdata_d = accept ? wr_data : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bank_q  <= 1'b0;
            dirty_q <= 1'b0;
            drain_q <= 8'd0;
            arm_q   <= '0;
            rej_q   <= 8'd0;
            err_q   <= 1'b0;
            owe_q   <= 1'b0;
            swe_q   <= 1'b0;
            ack_q   <= 1'b0;
            waddr_q <= 8'd0;
            wdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            dirty_q <= dirty_d;
            drain_q <= drain_d;
            arm_q   <= arm_d;
            rej_q   <= rej_d;
            err_q   <= err_d;
            owe_q   <= owe_d;
            swe_q   <= swe_d;
            ack_q   <= ack_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bank       = bank_q;
    assign offs_we    = owe_q;
    assign slope_we   = swe_q;
    assign wr_ack     = ack_q;
    assign ram_waddr  = waddr_q;
    assign ram_wdata  = wdata_q;
    assign state_o    = state_q;
    assign dirty      = dirty_q;
    assign reject_cnt = rej_q;
    assign swap_err   = err_q;

endmodule
